ram_port_arbiter: RTL and testbench

Shares one single-port synchronous RAM (registered read, one access per cycle) among NUM_REQ requesters. Each requester issues read/write commands through a valid/ready handshake. A round-robin arbiter grants at most one command per cycle and drives the RAM port from registers. Read data returns to the issuing requester after a fixed latency.

---
 rtl/ram_arb_pkg.sv | 15 +
 rtl/ram_port_arbiter_if.sv | 28 ++
 rtl/ram_port_arbiter_rr_arbiter.sv | 40 ++++
 rtl/ram_port_arbiter.sv | 92 +++++++++
 tb/tb_ram_port_arbiter.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared id-width helper, response tag type and requester limit
package ram_arb_pkg;
    localparam int MAX_REQ = 8;

    function automatic int ID_W(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int TAG_ID_W = ID_W(MAX_REQ);

    typedef struct packed {
        logic                vld;
        logic [TAG_ID_W-1:0] id;
    } tag_t;
endpackage

// File: rtl/ram_port_arbiter_if.sv
// ram_port_arbiter_if: requester command/response bundle plus the shared RAM port
interface ram_port_arbiter_if #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0]            req_wr;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
    logic [NUM_REQ-1:0]            rsp_valid;
    logic [DATA_WIDTH-1:0]         rsp_rdata;
    logic                          ram_wrn;
    logic [ADDR_WIDTH-1:0]         ram_addr;
    logic [DATA_WIDTH-1:0]         ram_din;
    logic [DATA_WIDTH-1:0]         ram_dout;

    modport master (
        output req_valid, req_wr, req_addr, req_wdata, ram_dout,
        input  req_ready, rsp_valid, rsp_rdata, ram_wrn, ram_addr, ram_din
    );

    modport slave (
        input  req_valid, req_wr, req_addr, req_wdata, ram_dout,
        output req_ready, rsp_valid, rsp_rdata, ram_wrn, ram_addr, ram_din
    );
endinterface

// File: rtl/ram_port_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin grant over N requests; owns the priority pointer
module rr_arbiter
    import ram_arb_pkg::*;
#(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] i_req,
    input  logic         i_advance,
    output logic [N-1:0] o_gnt
);
    localparam int PW = ID_W(N);

    logic [PW-1:0] r_prio;
    logic [PW-1:0] w_idx;
    logic [PW:0]   w_sum;
    logic          w_found;

    always_comb begin
        o_gnt   = '0;
        w_idx   = '0;
        w_sum   = '0;
        w_found = 1'b0;
        for (int k = 0; k < N; k++) begin
            w_sum = {1'b0, r_prio} + (PW+1)'(k);
            if (w_sum >= (PW+1)'(N)) w_sum = w_sum - (PW+1)'(N);
            if (!w_found && i_req[w_sum[PW-1:0]]) begin
                w_found = 1'b1;
                w_idx   = w_sum[PW-1:0];
            end
        end
        if (w_found) o_gnt[w_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         r_prio <= '0;
        else if (i_advance) r_prio <= (w_idx == PW'(N-1)) ? '0 : w_idx + 1'b1;
    end
endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: round-robin sharing of one registered-read RAM port among NUM_REQ requesters.
// Define RAM_ARB_WRACK_EN to make writes return an rsp_valid acknowledge like reads.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int NUM_REQ    = 2,
    parameter int RD_LATENCY = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    ram_port_arbiter_if.slave  bus
);
    localparam int IW = ID_W(NUM_REQ);

    logic [NUM_REQ-1:0]    w_gnt;
    logic [NUM_REQ-1:0]    w_rsp;
    logic                  w_hs;
    logic                  w_push;
    logic [IW-1:0]         w_sel;
    logic                  w_wr;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic                  r_wrn;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_din;
    tag_t                  r_tag [RD_LATENCY+1];

    // Masking requests with rst_n keeps req_ready low for the whole reset window.
    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req     (bus.req_valid & {NUM_REQ{rst_n}}),
        .i_advance (w_hs),
        .o_gnt     (w_gnt)
    );

    assign w_hs = |w_gnt;

    always_comb begin
        w_sel   = '0;
        w_wr    = 1'b0;
        w_addr  = '0;
        w_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt[i]) begin
                w_sel   = IW'(i);
                w_wr    = bus.req_wr[i];
                w_addr  = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                w_wdata = bus.req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

`ifdef RAM_ARB_WRACK_EN
    assign w_push = w_hs;
`else
    assign w_push = w_hs & ~w_wr;
`endif

    // Tag depth RD_LATENCY+1 covers the port register stage plus the RAM read latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrn  <= 1'b0;
            r_addr <= '0;
            r_din  <= '0;
            for (int i = 0; i <= RD_LATENCY; i++) r_tag[i] <= '0;
        end else begin
            r_wrn <= w_hs & w_wr;
            if (w_hs) begin
                r_addr <= w_addr;
                r_din  <= w_wdata;
            end
            r_tag[0] <= tag_t'{vld: w_push, id: TAG_ID_W'(w_sel)};
            for (int i = 1; i <= RD_LATENCY; i++) r_tag[i] <= r_tag[i-1];
        end
    end

    always_comb begin
        w_rsp = '0;
        for (int i = 0; i < NUM_REQ; i++)
            w_rsp[i] = r_tag[RD_LATENCY].vld && (r_tag[RD_LATENCY].id == TAG_ID_W'(i));
    end

    assign bus.req_ready = w_gnt;
    assign bus.rsp_valid = w_rsp;
    assign bus.rsp_rdata = bus.ram_dout;
    assign bus.ram_wrn   = r_wrn;
    assign bus.ram_addr  = r_addr;
    assign bus.ram_din   = r_din;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed and random traffic checked every cycle against a behavioural model
module tb_ram_port_arbiter;
    localparam int N = 2;
    localparam int L = 1;

    typedef struct {
        int          cyc;
        int          id;
        logic [31:0] data;
        bit          wr;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  v = '0;
    logic [1:0]  w = '0;
    logic [9:0]  ad [N] = '{default: '0};
    logic [31:0] wd [N] = '{default: '0};
    logic [1:0]  acc = '0;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    logic [31:0] mem    [1024] = '{default: '0};
    logic [31:0] m_mem  [1024] = '{default: '0};
    logic [31:0] rd_pipe [L];

    int          m_prio = 0;
    bit          m_wrn = 0;
    int          m_addr = 0;
    logic [31:0] m_din = '0;
    ev_t         exp_q[$];
    ev_t         obs[$];
    ev_t         hs_log[$];

    ram_port_arbiter_if #(.NUM_REQ(N), .ADDR_WIDTH(10), .DATA_WIDTH(32)) bus ();

    ram_port_arbiter #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (10),
        .NUM_REQ    (N),
        .RD_LATENCY (L)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign bus.req_valid = v;
    assign bus.req_wr    = w;
    assign bus.req_addr  = {ad[1], ad[0]};
    assign bus.req_wdata = {wd[1], wd[0]};
    assign bus.ram_dout  = rd_pipe[L-1];

    // Plain synchronous RAM: write at the edge, registered read with L cycles latency.
    always @(posedge clk) begin
        if (bus.ram_wrn) mem[bus.ram_addr] <= bus.ram_din;
        rd_pipe[0] <= mem[bus.ram_addr];
        for (int i = 1; i < L; i++) rd_pipe[i] <= rd_pipe[i-1];
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, act, exp);
        end
    endtask

    // Reference: search from prio for the first valid; reads return memory as of acceptance.
    always @(negedge clk) begin
        ev_t        e;
        logic [1:0] eg;
        logic [1:0] erv;
        int         gi;
        bit         have;
        if (!rst_n) begin
            chk("rst_ready", 64'(bus.req_ready), 64'd0);
            chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
            chk("rst_ram_wrn", 64'(bus.ram_wrn), 64'd0);
            chk("rst_ram_addr", 64'(bus.ram_addr), 64'd0);
            chk("rst_ram_din", 64'(bus.ram_din), 64'd0);
            m_prio = 0;
            m_wrn  = 0;
            m_addr = 0;
            m_din  = '0;
            exp_q.delete();
        end else begin
            if (m_wrn) m_mem[m_addr] = m_din;
            gi = -1;
            for (int k = 0; k < N; k++)
                if (gi < 0 && v[(m_prio + k) % N]) gi = (m_prio + k) % N;
            eg = '0;
            if (gi >= 0) eg[gi] = 1'b1;
            chk("ready", 64'(bus.req_ready), 64'(eg));
            erv  = '0;
            have = 0;
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                e = exp_q.pop_front();
                have = 1;
                erv[e.id] = 1'b1;
            end
            chk("rsp_valid", 64'(bus.rsp_valid), 64'(erv));
            if (have && !e.wr) chk("rsp_rdata", 64'(bus.rsp_rdata), 64'(e.data));
            chk("ram_wrn", 64'(bus.ram_wrn), 64'(m_wrn));
            chk("ram_addr", 64'(bus.ram_addr), 64'(m_addr));
            chk("ram_din", 64'(bus.ram_din), 64'(m_din));
            for (int i = 0; i < N; i++)
                if (bus.rsp_valid[i]) obs.push_back('{cyc, i, bus.rsp_rdata, 1'b0});
            if (gi >= 0) begin
                hs_log.push_back('{cyc, gi, wd[gi], w[gi]});
                m_prio = (gi + 1) % N;
                m_wrn  = w[gi];
                m_addr = int'(ad[gi]);
                m_din  = wd[gi];
                if (!w[gi]) exp_q.push_back('{cyc + 1 + L, gi, m_mem[ad[gi]], 1'b0});
`ifdef RAM_ARB_WRACK_EN
                else exp_q.push_back('{cyc + 1 + L, gi, 32'd0, 1'b1});
`endif
            end else begin
                m_wrn = 0;
            end
        end
        cyc++;
    end

    task automatic tick();
        @(negedge clk);
        acc = bus.req_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int i, input bit wr, input int a, input logic [31:0] d);
        int n;
        n = 0;
        v[i]  = 1'b1;
        w[i]  = wr;
        ad[i] = 10'(a);
        wd[i] = d;
        do begin
            tick();
            n++;
        end while (!acc[i] && n < 20);
        if (!acc[i]) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout req=%0d got=no_accept exp=accept", i);
        end
        v[i] = 1'b0;
    endtask

    initial begin
        int cnt;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // Requester 0: write i*i to 0..9, then read them back.
        obs.delete();
        hs_log.delete();
        for (int i = 0; i < 10; i++) send(0, 1'b1, i, 32'(i * i));
        for (int i = 0; i < 10; i++) send(0, 1'b0, i, 32'd0);
        repeat (4) tick();
        chk("single_n_rsp", 64'(obs.size()), 64'd10);
        chk("single_n_hs", 64'(hs_log.size()), 64'd20);
        if (hs_log.size() == 20 && obs.size() == 10) begin
            chk("single_b2b", 64'(hs_log[19].cyc - hs_log[0].cyc), 64'd19);
            chk("single_lat", 64'(obs[0].cyc - hs_log[10].cyc), 64'd2);
            for (int i = 0; i < 10; i++) chk("single_data", 64'(obs[i].data), 64'(i * i));
            chk("single_rsp_b2b", 64'(obs[9].cyc - obs[0].cyc), 64'd9);
        end

        // Read accepted just before an asynchronous reset must never respond.
        obs.delete();
        v[1] = 1'b0;
        send(0, 1'b0, 4, 32'd0);
        rst_n = 1'b0;
        v = 2'b11;
        repeat (3) tick();
        v = 2'b00;
        rst_n = 1'b1;
        repeat (4) tick();
        chk("reset_drop", 64'(obs.size()), 64'd0);

        // Both requesters saturated: grants and responses alternate.
        obs.delete();
        hs_log.delete();
        ad[0] = 10'd5;
        ad[1] = 10'd7;
        w = 2'b00;
        v = 2'b11;
        repeat (8) tick();
        v = 2'b00;
        repeat (3) tick();
        chk("cont_n_hs", 64'(hs_log.size()), 64'd8);
        chk("cont_n_rsp", 64'(obs.size()), 64'd8);
        for (int j = 0; j < 8 && j < hs_log.size() && j < obs.size(); j++) begin
            chk("cont_gnt", 64'(hs_log[j].id), 64'(j % 2));
            chk("cont_id", 64'(obs[j].id), 64'(j % 2));
            chk("cont_data", 64'(obs[j].data), (j % 2) ? 64'd49 : 64'd25);
        end

        // Write from requester 1 immediately followed by a read of the same address.
        obs.delete();
        hs_log.delete();
        send(1, 1'b1, 3, 32'hDEAD);
        send(0, 1'b0, 3, 32'd0);
        repeat (4) tick();
        chk("hazard_n_rsp", 64'(obs.size()), 64'd1);
        if (obs.size() == 1) begin
            chk("hazard_id", 64'(obs[0].id), 64'd0);
            chk("hazard_data", 64'(obs[0].data), 64'hDEAD);
        end
        if (hs_log.size() == 2) chk("hazard_b2b", 64'(hs_log[1].cyc - hs_log[0].cyc), 64'd1);

        // Idle gap: port holds last address, priority resumes after requester 0.
        repeat (5) tick();
        chk("idle_wrn", 64'(bus.ram_wrn), 64'd0);
        chk("idle_addr", 64'(bus.ram_addr), 64'd3);
        ad[0] = 10'd0;
        ad[1] = 10'd1;
        w = 2'b00;
        v = 2'b11;
        tick();
        chk("idle_resume", 64'(acc), 64'd2);
        v = 2'b00;
        repeat (3) tick();

        // Write acknowledges only exist when the option is compiled in.
        obs.delete();
        hs_log.delete();
        for (int j = 0; j < 4; j++) send(1, 1'b1, 20 + j, 32'(j + 100));
        repeat (4) tick();
        cnt = 0;
        foreach (obs[j]) if (obs[j].id == 1) cnt++;
`ifdef RAM_ARB_WRACK_EN
        chk("wrack_n", 64'(cnt), 64'd4);
        for (int j = 0; j < 4 && j < obs.size() && j < hs_log.size(); j++)
            chk("wrack_lat", 64'(obs[j].cyc - hs_log[j].cyc), 64'd2);
`else
        chk("wrack_n", 64'(cnt), 64'd0);
`endif

        // Random traffic; each requester holds its command until accepted.
        acc = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!v[i] || acc[i]) begin
                    v[i]  = ($urandom_range(0, 9) < 6);
                    w[i]  = 1'($urandom_range(0, 1));
                    ad[i] = 10'($urandom_range(0, 15));
                    wd[i] = $urandom;
                end
            end
            tick();
        end
        v = 2'b00;
        repeat (5) tick();
        chk("drain_empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
